instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Fetch stage directly upstream of `ControlUnit`: owns the PC, issues requests to instruction memory over a req/ack handshake, and captures returned words. Each captured word is split into the fields `ControlUnit` consumes (`op`, `inst`, `immediatei`) plus register and immediate fields for the register file and extender. A one-entry skid buffer absorbs a word returning while decode is stalled. A redirect flushes everything in flight.

## Interface
Parameters:
- `ADDR_W`, 32: PC / memory address width.
- `INSTR_W`, 32: instruction width; field positions below assume 32.
- `RESET_PC`, 32'h0: PC loaded on reset.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: one clock; reset is asynchronous and active-low.
- `stall`  in  1: decode/hazard stall; output register holds.
- `redirect`  in  1: branch/jump taken; flush and reload PC.
- `redirect_pc`  in  ADDR_W: new PC, sampled when `redirect`=1.
- `imem_req`  out  1: fetch request, registered.
- `imem_addr`  out  ADDR_W: request address, registered.
- `imem_ack`  in  1: one-cycle pulse; `imem_rdata` valid this cycle.
- `imem_rdata`  in  INSTR_W: returned instruction.
- `out_valid`  out  1: fields below are valid.
- `out_pc`  out  ADDR_W: PC of the presented instruction.
- `out_instr`  out  INSTR_W: raw word.
- `op`  out  2: `instr[31:30]` to `ControlUnit`.
- `inst`  out  2: `instr[29:28]` to `ControlUnit`.
- `immediatei`  out  1: `instr[27]` to `ControlUnit`.
- `rd`, `rs1`, `rs2`  out  4 each: `instr[26:23]`, `[22:19]`, `[18:15]`.
- `imm_raw`  out  19: `instr[18:0]`, unextended; extended downstream under `ExtndSel`.

## Operation
- States: IDLE (reset), FETCH (request outstanding), FULL (skid holds a word; no request), DROP (redirected while a request is outstanding; discard its data).
- IDLE goes to FETCH after one cycle; `imem_req` rises with `imem_addr`=`RESET_PC`.
- Handshake: once `imem_req`=1, it and `imem_addr` stay constant until the `imem_ack` cycle.
- FETCH with ack, when `!out_valid || !stall`:
  - word loads into the output register;
  - `imem_addr` becomes the acked address + 4;
  - state stays FETCH, so requests run back-to-back.
- FETCH with ack, when `out_valid && stall`:
  - word and PC load into the skid buffer;
  - state goes to FULL and `imem_req` drops.
- FULL with `!stall`: skid moves to the output register; state goes to FETCH and `imem_req` rises next cycle.
- Output register with `!stall` and no new word: `out_valid` goes to 0.
- Redirect has priority over stall and ack:
  - `out_valid` and the skid buffer are cleared; PC is set to `redirect_pc`.
  - Redirect in FETCH without ack: go to DROP; `imem_req` and `imem_addr` hold at the old address until ack.
  - On that ack, discard the data and go to FETCH at `redirect_pc`.
  - Redirect with ack in the same cycle: discard the data and go straight to FETCH at `redirect_pc`.
  - Redirect in DROP: update the target PC and stay in DROP.
  - Redirect in FULL: go to FETCH at `redirect_pc`.
- PC arithmetic is modulo 2^ADDR_W; `32'hFFFF_FFFC`+4 wraps to 0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `out_valid`=0, `out_pc`=0, `out_instr`=0, and all field outputs 0. State is IDLE, skid empty.
- Reset mid-operation aborts any outstanding request immediately. Acks arriving during reset are ignored.
- Ack to `out_valid`: 1 cycle. The output register updates on the edge that samples ack.
- Field outputs are combinational slices of the registered `out_instr`; there is no extra latency into `ControlUnit`.
- Redirect to first new request: `imem_addr`=`redirect_pc` visible 1 cycle after redirect (FETCH/FULL), or 1 cycle after the pending ack (DROP).
- Maximum throughput: 1 instruction/cycle with single-cycle ack and no stall.

## Configuration
- `FETCH_PERF_EN` defined: adds output ports `perf_fetch_cnt[31:0]` and `perf_stall_cnt[31:0]`.
  - `perf_fetch_cnt` counts words delivered to the output register.
  - `perf_stall_cnt` counts cycles with `out_valid && stall`.
  - Both reset to 0 and wrap.
- `FETCH_PERF_EN` undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package `cpu_pkg` holds:
  - the `fetch_state_t` enum (IDLE, FETCH, FULL, DROP);
  - field bit-position constants for op, inst, imm flag, rd, rs1, rs2 and imm;
  - `PC_INC`=4.
- Sub-module `fetch_skid_buf`: one-entry buffer storing {pc, instr} with load/drain/clear inputs and a full flag. The FSM, PC and output register stay in the top module.

## Test plan
- Reset release with ack always 1 cycle later → `imem_addr` 0, 4, 8; `out_valid`=1 from cycle 2; `out_pc` 0, 4, 8. The word 32'h6880_0000 gives `op`=1, `inst`=2, `immediatei`=1, `rd`=1.
- Stall held 3 cycles while ack arrives for 0x8 → word goes to skid, `imem_req`=0. On stall release, `out_pc`=8 next cycle, then `imem_addr`=0xC.
- Redirect to 0x100 while request to 0x10 is outstanding, ack 2 cycles later → that word is never presented; next `imem_addr`=0x100; `out_valid`=0 until the 0x100 word arrives.
- Redirect and ack in the same cycle → acked word dropped; `imem_addr`=`redirect_pc` next cycle.
- `RESET_PC`=32'hFFFF_FFFC → second request address is 0.
- `rst` asserted mid-request, then released → `imem_req`=0 and `out_valid`=0 immediately; fetching restarts at `RESET_PC`. With `FETCH_PERF_EN` defined, counters read 0 after reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and instruction field positions for the fetch/decode boundary.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  // Field positions within a 32-bit instruction word.
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 30;
  localparam int INST_MSB = 29;
  localparam int INST_LSB = 28;
  localparam int IMMF_BIT = 27;
  localparam int RD_MSB   = 26;
  localparam int RD_LSB   = 23;
  localparam int RS1_MSB  = 22;
  localparam int RS1_LSB  = 19;
  localparam int RS2_MSB  = 18;
  localparam int RS2_LSB  = 15;
  localparam int IMM_MSB  = 18;
  localparam int IMM_LSB  = 0;

  localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding {pc, instr} for a word that returns while decode stalls.
module fetch_skid_buf #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               full,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  // NOTE: payload needs no reset; it is only ever read while full is set.
  always_ff @(posedge clk) begin
    if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, imem req/ack handshake, output register and ControlUnit field split.
// Optional FETCH_PERF_EN adds fetch/stall performance counters.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         op,
  output logic [1:0]         inst,
  output logic               immediatei,
  output logic [3:0]         rd,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [18:0]        imm_raw
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  fetch_state_t       state_q, state_d;
  logic               req_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;        // next fetch address while req is low or draining
  logic               out_valid_d;
  logic [ADDR_W-1:0]  out_pc_d;
  logic [INSTR_W-1:0] out_instr_d;
  logic               deliver;
  logic               skid_load, skid_drain, skid_clear, skid_full;
  logic [ADDR_W-1:0]  skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (skid_clear),
    .load_pc    (imem_addr),
    .load_instr (imem_rdata),
    .full       (skid_full),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_d       = imem_req;
    addr_d      = imem_addr;
    pc_d        = pc_q;
    out_valid_d = out_valid && stall;
    out_pc_d    = out_pc;
    out_instr_d = out_instr;
    deliver     = 1'b0;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_clear  = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        if (redirect) addr_d = redirect_pc;
      end
      FETCH: begin
        if (redirect) begin
          // With ack the word is simply dropped; without it we must wait it out.
          if (imem_ack) begin
            addr_d = redirect_pc;
          end else begin
            state_d = DROP;
            pc_d    = redirect_pc;
          end
        end else if (imem_ack) begin
          if (!out_valid || !stall) begin
            deliver     = 1'b1;
            out_valid_d = 1'b1;
            out_pc_d    = imem_addr;
            out_instr_d = imem_rdata;
            addr_d      = imem_addr + INC;
          end else begin
            skid_load = 1'b1;
            state_d   = FULL;
            req_d     = 1'b0;
            pc_d      = imem_addr + INC;
          end
        end
      end
      FULL: begin
        if (redirect) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = redirect_pc;
        end else if (!stall && skid_full) begin
          deliver     = 1'b1;
          skid_drain  = 1'b1;
          out_valid_d = 1'b1;
          out_pc_d    = skid_pc;
          out_instr_d = skid_instr;
          state_d     = FETCH;
          req_d       = 1'b1;
          addr_d      = pc_q;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d = FETCH;
          addr_d  = redirect ? redirect_pc : pc_q;
        end else if (redirect) begin
          pc_d = redirect_pc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      out_valid_d = 1'b0;
      skid_clear  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments; the comb block above uses blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      pc_q      <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
    end else begin
      state_q   <= state_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      pc_q      <= pc_d;
      out_valid <= out_valid_d;
      out_pc    <= out_pc_d;
      out_instr <= out_instr_d;
    end
  end

  assign op         = out_instr[OP_MSB:OP_LSB];
  assign inst       = out_instr[INST_MSB:INST_LSB];
  assign immediatei = out_instr[IMMF_BIT];
  assign rd         = out_instr[RD_MSB:RD_LSB];
  assign rs1        = out_instr[RS1_MSB:RS1_LSB];
  assign rs2        = out_instr[RS2_MSB:RS2_LSB];
  assign imm_raw    = out_instr[IMM_MSB:IMM_LSB];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (deliver)            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (out_valid && stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: reset, streaming, skid stall, redirects, PC wrap.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc, out_instr;
  logic [1:0]  op, inst;
  logic        immediatei;
  logic [3:0]  rd, rs1, rs2;
  logic [18:0] imm_raw;

  logic        req_b, ack_b, valid_b, immi_b;
  logic [31:0] addr_b, pc_b, instr_b;
  logic [1:0]  op_b, inst_b;
  logic [3:0]  rd_b, rs1_b, rs2_b;
  logic [18:0] imm_b;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, pf_b, ps_b;
`endif

  int checks = 0;
  int errors = 0;
  logic auto_ack;

  always #5 clk = ~clk;

  instr_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .op(op), .inst(inst), .immediatei(immediatei), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm_raw(imm_raw)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ack(ack_b), .imem_rdata(32'h1234_5678),
    .out_valid(valid_b), .out_pc(pc_b), .out_instr(instr_b),
    .op(op_b), .inst(inst_b), .immediatei(immi_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b),
    .imm_raw(imm_b)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(pf_b), .perf_stall_cnt(ps_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h6880_0000 : (32'hA000_0000 | a);
  endfunction

  // Zero-wait memory: ack in the same cycle a request is presented.
  task automatic drive_ack();
    imem_ack   = auto_ack & imem_req;
    imem_rdata = mem_word(imem_addr);
    ack_b      = req_b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_ack();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; ack_b = 1'b0; auto_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values, with a spurious ack held high throughout.
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_op", op, 0);
    check("rst_rd", rd, 0);
    check("rst_addr_wrap", addr_b, 32'hFFFF_FFFC);
    imem_ack = 1'b0;
    rst = 1'b1;
    auto_ack = 1'b1;

    step();  // IDLE -> FETCH
    check("e0_req", imem_req, 1);
    check("e0_addr", imem_addr, 0);
    check("e0_valid", out_valid, 0);
    check("e0_addr_wrap", addr_b, 32'hFFFF_FFFC);

    step();
    check("e1_valid", out_valid, 1);
    check("e1_pc", out_pc, 0);
    check("e1_instr", out_instr, 32'h6880_0000);
    check("e1_op", op, 1);
    check("e1_inst", inst, 2);
    check("e1_immi", immediatei, 1);
    check("e1_rd", rd, 1);
    check("e1_rs1", rs1, 0);
    check("e1_imm", imm_raw, 0);
    check("e1_addr", imem_addr, 4);
    check("wrap_addr", addr_b, 0);
    check("wrap_pc", pc_b, 32'hFFFF_FFFC);

    step();
    check("e2_pc", out_pc, 4);
    check("e2_addr", imem_addr, 8);

    // Stall while the 0x8 word returns: it goes to the skid buffer.
    stall = 1'b1;
    step();
    check("stall_req", imem_req, 0);
    check("stall_pc", out_pc, 4);
    check("stall_valid", out_valid, 1);
    step();
    step();
    check("stall3_req", imem_req, 0);
    check("stall3_pc", out_pc, 4);
    stall = 1'b0;

    step();
    check("drain_pc", out_pc, 8);
    check("drain_instr", out_instr, 32'hA000_0008);
    check("drain_req", imem_req, 1);
    check("drain_addr", imem_addr, 32'hC);

    step();
    check("e7_pc", out_pc, 32'hC);
    check("e7_addr", imem_addr, 32'h10);

    // Redirect while 0x10 is outstanding; its ack arrives two cycles later.
    auto_ack = 1'b0; imem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    check("drop_valid", out_valid, 0);
    check("drop_req", imem_req, 1);
    check("drop_addr", imem_addr, 32'h10);
    redirect = 1'b0;
    step();
    check("drop_hold_addr", imem_addr, 32'h10);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h10);
    step();
    check("drop_done_addr", imem_addr, 32'h100);
    check("drop_done_valid", out_valid, 0);
    auto_ack = 1'b1;
    drive_ack();
    step();
    check("tgt_valid", out_valid, 1);
    check("tgt_pc", out_pc, 32'h100);
    check("tgt_addr", imem_addr, 32'h104);

    // Redirect in the same cycle as the ack for 0x104.
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    check("rdack_valid", out_valid, 0);
    check("rdack_addr", imem_addr, 32'h200);
    check("rdack_req", imem_req, 1);
    redirect = 1'b0;
    step();
    check("r2_valid", out_valid, 1);
    check("r2_pc", out_pc, 32'h200);
    check("r2_instr", out_instr, 32'hA000_0200);
`ifdef FETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, 6);
    check("perf_stall", perf_stall_cnt, 3);
`endif

    // No stall and no new word: output goes invalid.
    auto_ack = 1'b0; imem_ack = 1'b0;
    step();
    check("idle_valid", out_valid, 0);
    check("idle_req", imem_req, 1);

    // Reset in the middle of an outstanding request.
    rst = 1'b0;
    #1;
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_addr", imem_addr, 0);
`ifdef FETCH_PERF_EN
    check("mid_rst_pf", perf_fetch_cnt, 0);
    check("mid_rst_ps", perf_stall_cnt, 0);
`endif
    step();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    step();
    check("rst_ack_req", imem_req, 0);
    check("rst_ack_valid", out_valid, 0);
    imem_ack = 1'b0;
    rst = 1'b1;
    auto_ack = 1'b1;
    step();
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 0);
    step();
    check("restart_valid", out_valid, 1);
    check("restart_pc", out_pc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
